// File: rtl/mux_rr_stream.sv
// Registered N-to-1 valid/ready stream mux with manual select or
// round-robin arbitration with burst hold.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_data/valid/ready  CHANNELS input streams, channel k at [k*WIDTH +: WIDTH]
//   mode                 0 = manual (sel), 1 = round-robin
//   sel                  channel index used in manual mode
//   out_data/chan/valid  registered output beat and its source channel
//   out_ready            downstream accept
module mux_rr_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2,
  parameter int BURST    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [7:0] BURST_C = 8'(BURST);
  localparam logic [SELW-1:0] LAST_C = SELW'(CHANNELS - 1);

  logic [SELW-1:0]  last_grant;
  logic [SELW-1:0]  grant;
  logic [7:0]       beat_cnt;
  logic             grant_ok;
  logic             load;
  logic             lg_valid;
  logic             hold;
  logic [WIDTH-1:0] gdata;
  int               idx;

  // one-deep output register: refill when empty or being drained
  assign load = !out_valid || out_ready;

  always_comb begin
    lg_valid = 1'b0;
    for (int k = 0; k < CHANNELS; k++)
      if (SELW'(k) == last_grant)
        lg_valid = in_valid[k];
  end

  // beat_cnt is zero after reset and in manual mode, so
  // entering round-robin always starts a fresh search
  assign hold = (beat_cnt != 8'd0) && (beat_cnt < BURST_C) && lg_valid;

  always_comb begin
    grant_ok = 1'b0;
    grant    = '0;
    idx      = 0;
    if (!mode) begin
      // out-of-range sel matches no k and so never grants
      for (int k = 0; k < CHANNELS; k++)
        if (SELW'(k) == sel && in_valid[k]) begin
          grant_ok = 1'b1;
          grant    = SELW'(k);
        end
    end else if (hold) begin
      grant_ok = 1'b1;
      grant    = last_grant;
    end else begin
      // scan farthest offset first so the nearest valid wins
      for (int off = CHANNELS; off >= 1; off--) begin
        idx = (int'(last_grant) + off) % CHANNELS;
        for (int k = 0; k < CHANNELS; k++)
          if (k == idx && in_valid[k]) begin
            grant_ok = 1'b1;
            grant    = SELW'(k);
          end
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (SELW'(k) == grant)
        gdata = in_data[k*WIDTH +: WIDTH];
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < CHANNELS; k++)
      in_ready[k] = rst_n && load && grant_ok && (grant == SELW'(k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_chan   <= '0;
      out_valid  <= 1'b0;
      last_grant <= LAST_C;
      beat_cnt   <= 8'd0;
    end else begin
      if (load) begin
        if (grant_ok) begin
          out_data   <= gdata;
          out_chan   <= grant;
          out_valid  <= 1'b1;
          last_grant <= grant;
        end else begin
          out_valid  <= 1'b0;
        end
      end
      if (!mode)
        beat_cnt <= 8'd0;
      else if (load && grant_ok) begin
        if (grant != last_grant || beat_cnt == BURST_C)
          beat_cnt <= 8'd1;
        else
          beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: two instances (BURST=1 and BURST=3)
// share stimulus; the BURST=1 one is tracked by a scoreboard.
module tb_mux_rr_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        mode;
  logic [2:0]  sel;
  logic        out_ready;

  logic [3:0]  a_in_ready, b_in_ready;
  logic [7:0]  a_out_data, b_out_data;
  logic [2:0]  a_out_chan, b_out_chan;
  logic        a_out_valid, b_out_valid;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] d;
  } ent_t;

  ent_t       q[$];
  logic [7:0] chd[4];
  logic [7:0] last_d;
  int         seed = 0;
  bit         hold_data = 1'b0;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  mux_rr_stream #(.WIDTH(8), .CHANNELS(4), .SELW(3), .BURST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .mode(mode), .sel(sel),
    .out_data(a_out_data), .out_chan(a_out_chan),
    .out_valid(a_out_valid), .out_ready(out_ready));

  mux_rr_stream #(.WIDTH(8), .CHANNELS(4), .SELW(3), .BURST(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .mode(mode), .sel(sel),
    .out_data(b_out_data), .out_chan(b_out_chan),
    .out_valid(b_out_valid), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    if (!hold_data) begin
      seed++;
      for (int k = 0; k < 4; k++)
        chd[k] = {4'(seed), 4'(k)};
    end
    for (int k = 0; k < 4; k++)
      in_data[k*8 +: 8] = chd[k];
  endtask

  // exp_a: channel dut_a must accept this cycle (-1 none)
  // exp_b: out_chan dut_b must show after the edge (-1 skip)
  task automatic tick(input int exp_a, input int exp_b);
    ent_t e;
    logic [3:0] oh;
    drive_data();
    #1;
    oh = (exp_a < 0) ? 4'b0000 : 4'(1 << exp_a);
    chk("a_valid", 32'(a_out_valid), 32'(q.size() != 0));
    chk("a_in_ready", 32'(a_in_ready), 32'(oh));
    if (q.size() != 0 && out_ready) begin
      e = q.pop_front();
      chk("sb_chan", 32'(a_out_chan), 32'(e.ch));
      chk("sb_data", 32'(a_out_data), 32'(e.d));
    end
    if (exp_a >= 0) begin
      e.ch = 3'(exp_a);
      e.d  = chd[exp_a];
      last_d = e.d;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (exp_b >= 0)
      chk("b_chan", 32'(b_out_chan), 32'(exp_b));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 4'hF;
    mode = 1'b1;
    sel = 3'd0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) chd[k] = 8'h00;
    in_data = '0;
    #1;
    chk("rst_valid", 32'(a_out_valid), 32'd0);
    chk("rst_ready", 32'(a_in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(a_out_data), 32'd0);
    chk("rst_chan", 32'(a_out_chan), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin, all valid
    tick(0, 0); tick(1, 0); tick(2, 0); tick(3, 1);
    tick(0, 1); tick(1, 1); tick(2, 2); tick(3, 2);

    // sparse: only ch1 and ch3
    in_valid = 4'b1010;
    tick(1, 3); tick(3, 3); tick(1, 3); tick(3, 1);

    // wrap from ch3 to ch0
    in_valid = 4'b0001;
    tick(0, 0);

    // nothing valid: output empties, data holds
    in_valid = 4'b0000;
    tick(-1, -1);
    chk("idle_valid", 32'(a_out_valid), 32'd0);
    chk("idle_chan", 32'(a_out_chan), 32'd0);
    chk("idle_data", 32'(a_out_data), 32'(last_d));

    // reset while a beat is in the output register
    in_valid = 4'hF;
    tick(1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_data", 32'(a_out_data), 32'd0);
    chk("mid_rst_chan", 32'(a_out_chan), 32'd0);
    chk("mid_rst_bvalid", 32'(b_out_valid), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // first grant after reset is ch0; ch0 drops mid-burst
    tick(0, 0); tick(1, 0);
    in_valid = 4'b1110;
    tick(2, 1);

    // backpressure
    in_valid = 4'hF;
    tick(3, -1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(-1, -1);
      chk("bp_chan", 32'(a_out_chan), 32'd3);
      chk("bp_data", 32'(a_out_data), 32'(q[0].d));
    end
    out_ready = 1'b1;
    tick(0, -1);

    // manual mode
    mode = 1'b0;
    sel = 3'd2;
    hold_data = 1'b1;
    chd[2] = 8'hA5;
    tick(2, 2);
    chk("man_data", 32'(a_out_data), 32'hA5);
    sel = 3'd5;
    hold_data = 1'b0;
    tick(-1, -1);
    chk("man_oor_valid", 32'(a_out_valid), 32'd0);
    tick(-1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
